// File: rtl/fetch_stage.sv
// Fetch stage: sequential PC generation, in-order imem requests with a bounded
// in-flight + buffered budget, and a uop buffer toward decode with redirect flush.
// Optional `FETCH_STAGE_PERF_CNT_EN adds perfFetched/perfDiscarded counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        dValid,
  input  logic        dStall,
  output logic [63:0] uopOut,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc
`ifdef FETCH_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] perfFetched,
  output logic [31:0] perfDiscarded
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [IW-1:0] LAST = IW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding, discard, fifoCount, outstandingNext;
  logic [IW-1:0] tagWr, tagRd, respWr, respRd;
  logic [31:0]   tagMem  [MAX_OUTSTANDING];
  logic [63:0]   respMem [MAX_OUTSTANDING];
  logic          accept, respDrop, respPush, xfer;
  logic [SW-1:0] occupancy;

  function automatic logic [IW-1:0] bump(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Capacity counts stale in-flight requests too, so a redirect never overfills the buffer.
  assign occupancy    = {1'b0, outstanding} + {1'b0, fifoCount};
  assign imemReqValid = !rst && (occupancy < SW'(MAX_OUTSTANDING));
  assign imemReqAddr  = pc;

  assign accept   = imemReqValid && imemReqReady;
  assign respDrop = imemRespValid && (discard != '0);
  assign respPush = imemRespValid && (discard == '0) && !redirectValid;
  assign xfer     = dValid && !dStall;

  assign outstandingNext = outstanding + CW'(accept) - CW'(imemRespValid);

  assign dValid = (fifoCount != '0);
  assign uopOut = dValid ? respMem[respRd] : '0;

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifoCount   <= '0;
      tagWr       <= '0;
      tagRd       <= '0;
      respWr      <= '0;
      respRd      <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (accept)        tagWr <= bump(tagWr);
      if (imemRespValid) tagRd <= bump(tagRd);
      if (redirectValid) begin
        // Everything still in flight after this edge belongs to the old path.
        pc        <= redirectPc & 32'hFFFF_FFFC;
        discard   <= outstandingNext;
        fifoCount <= '0;
        respWr    <= respRd;
      end else begin
        if (accept)   pc      <= pc + 32'd4;
        if (respDrop) discard <= discard - 1'b1;
        if (respPush) respWr  <= bump(respWr);
        if (xfer)     respRd  <= bump(respRd);
        fifoCount <= fifoCount + CW'(respPush) - CW'(xfer);
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone define which entries are live.
  always_ff @(posedge clk) begin
    if (accept)   tagMem[tagWr]   <= pc;
    if (respPush) respMem[respWr] <= {tagMem[tagRd], imemRespData};
  end

`ifdef FETCH_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfFetched   <= '0;
      perfDiscarded <= '0;
    end else begin
      if (xfer) perfFetched <= perfFetched + 32'd1;
      if (redirectValid)
        perfDiscarded <= perfDiscarded + 32'(fifoCount) - 32'(xfer) + 32'(imemRespValid);
      else if (respDrop)
        perfDiscarded <= perfDiscarded + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus a queue-level
// reference of buffered uops, stale in-flight requests and the next fetch PC.
module tb_fetch_stage;

  localparam int          MAX = 2;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dValid;
  logic        dStall = 1'b0;
  logic [63:0] uopOut;
  logic        imemReqValid;
  logic        imemReqReady = 1'b0;
  logic [31:0] imemReqAddr;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = 32'h0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .dValid(dValid), .dStall(dStall), .uopOut(uopOut),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .redirectValid(redirectValid), .redirectPc(redirectPc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] enc; } uop_t;

  req_t        memQ[$];   // requests accepted by memory, oldest first
  uop_t        bufQ[$];   // uops the stage should currently be holding for decode
  logic [31:0] mPc = RPC;
  int          cyc = 0;
  int          nCompared = 0;
  int          nMismatched = 0;

  function automatic logic [31:0] encOf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit expReqValid();
    return !rst && ((memQ.size() + bufQ.size()) < MAX);
  endfunction

  function automatic logic [63:0] expUop();
    return (bufQ.size() != 0) ? {bufQ[0].pc, bufQ[0].enc} : 64'h0;
  endfunction

  task automatic modelReset();
    memQ.delete();
    bufQ.delete();
    mPc = RPC;
  endtask

  // One clock: drive inputs, let the memory answer the oldest due request, advance the model.
  task automatic cycle(input bit ready, input bit stall, input bit redir,
                       input logic [31:0] rpc, input int lat, input bit respHold);
    bit          acc, rsp, xf;
    logic [31:0] a;
    req_t        r;
    uop_t        u;
    imemReqReady  = ready;
    dStall        = stall;
    redirectValid = redir;
    redirectPc    = rpc;
    rsp = !respHold && (memQ.size() != 0) && (memQ[0].due <= cyc);
    imemRespValid = rsp;
    imemRespData  = rsp ? encOf(memQ[0].addr) : $urandom;
    #1;
    acc = imemReqValid && ready;
    a   = imemReqAddr;
    xf  = (bufQ.size() != 0) && !stall;
    @(posedge clk);
    if (xf) void'(bufQ.pop_front());
    if (rsp) begin
      r = memQ.pop_front();
      if (!r.stale && !redir) begin
        u.pc  = r.addr;
        u.enc = encOf(r.addr);
        bufQ.push_back(u);
      end
    end
    if (redir) begin
      bufQ.delete();
      foreach (memQ[i]) memQ[i].stale = 1'b1;
    end
    if (acc) begin
      r.addr  = a;
      r.due   = cyc + 1 + lat;
      r.stale = redir;
      memQ.push_back(r);
    end
    if (redir)    mPc = rpc & 32'hFFFF_FFFC;
    else if (acc) mPc = mPc + 32'd4;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((memQ.size() != 0 || bufQ.size() != 0) && n < 60) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      n++;
    end
    nCompared++;
    if (dValid !== 1'b0 || n == 60) begin
      nMismatched++;
      $display("FAIL drain: dValid=%0b after %0d cycles, want 0 within 60", dValid, n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    nCompared++;
    if (dValid !== 1'b0) begin nMismatched++; $display("FAIL reset_dvalid: got %0b want 0", dValid); end
    nCompared++;
    if (imemReqValid !== 1'b0) begin nMismatched++; $display("FAIL reset_reqvalid: got %0b want 0", imemReqValid); end
    nCompared++;
    if (uopOut !== 64'h0) begin nMismatched++; $display("FAIL reset_uop: got %h want 0", uopOut); end
    nCompared++;
    if (imemReqAddr !== RPC) begin nMismatched++; $display("FAIL reset_addr: got %h want %h", imemReqAddr, RPC); end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    nCompared++;
    if (imemReqValid !== 1'b1) begin nMismatched++; $display("FAIL first_req: got %0b want 1", imemReqValid); end
  endtask

  task automatic test_sequential();
    int issued = 0;
    int delivered = 0;
    logic [31:0] p;
    for (int i = 0; i < 12; i++) begin
      if (dValid === 1'b1) begin
        p = RPC + 32'(4 * delivered);
        nCompared++;
        if (uopOut !== {p, encOf(p)}) begin
          nMismatched++;
          $display("FAIL seq_uop: got %h want %h", uopOut, {p, encOf(p)});
        end
        delivered++;
      end
      if (imemReqValid === 1'b1) begin
        nCompared++;
        if (imemReqAddr !== RPC + 32'(4 * issued)) begin
          nMismatched++;
          $display("FAIL seq_addr: got %h want %h", imemReqAddr, RPC + 32'(4 * issued));
        end
        issued++;
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      nCompared++;
      if (imemReqValid !== expReqValid()) begin
        nMismatched++;
        $display("FAIL seq_reqvalid: got %0b want %0b", imemReqValid, expReqValid());
      end
    end
    nCompared++;
    if (delivered < 6) begin nMismatched++; $display("FAIL seq_progress: got %0d uops want >=6", delivered); end
  endtask

  task automatic test_req_stall();
    logic [31:0] a0;
    drain();
    a0 = imemReqAddr;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      nCompared++;
      if (imemReqAddr !== a0 || imemReqValid !== 1'b1) begin
        nMismatched++;
        $display("FAIL req_hold: addr=%h valid=%0b want addr=%h valid=1", imemReqAddr, imemReqValid, a0);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    nCompared++;
    if (imemReqAddr !== a0 + 32'd4) begin
      nMismatched++;
      $display("FAIL req_single: got %h want %h", imemReqAddr, a0 + 32'd4);
    end
  endtask

  task automatic test_decode_stall();
    logic [31:0] startPc, nextPc;
    int delivered = 0;
    drain();
    startPc = imemReqAddr;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 0, 1'b0);
      if (i >= 1) begin
        nCompared++;
        if (dValid !== 1'b1 || uopOut !== {startPc, encOf(startPc)}) begin
          nMismatched++;
          $display("FAIL stall_hold: dValid=%0b uop=%h want 1 / %h", dValid, uopOut, {startPc, encOf(startPc)});
        end
        nCompared++;
        if (imemReqValid !== 1'b0) begin
          nMismatched++;
          $display("FAIL stall_full: imemReqValid=%0b want 0", imemReqValid);
        end
      end
    end
    nextPc = startPc;
    for (int i = 0; i < 8; i++) begin
      if (dValid === 1'b1) begin
        nCompared++;
        if (uopOut !== {nextPc, encOf(nextPc)}) begin
          nMismatched++;
          $display("FAIL stall_release: got %h want %h", uopOut, {nextPc, encOf(nextPc)});
        end
        nextPc = nextPc + 32'd4;
        delivered++;
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    end
    nCompared++;
    if (delivered < 4) begin nMismatched++; $display("FAIL stall_progress: got %0d uops want >=4", delivered); end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    drain();
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 0, 1'b0);
    nCompared++;
    if (imemReqAddr !== 32'h200) begin nMismatched++; $display("FAIL redir_a: got %h want 200", imemReqAddr); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 5, 1'b0);
    nCompared++;
    if (imemReqAddr !== 32'h204) begin nMismatched++; $display("FAIL redir_b: got %h want 204", imemReqAddr); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 5, 1'b0);
    nCompared++;
    if (imemReqValid !== 1'b0) begin nMismatched++; $display("FAIL redir_full: got %0b want 0", imemReqValid); end
    cycle(1'b0, 1'b0, 1'b1, 32'h400, 0, 1'b0);
    nCompared++;
    if (dValid !== 1'b0) begin nMismatched++; $display("FAIL redir_dvalid: got %0b want 0", dValid); end
    nCompared++;
    if (imemReqAddr !== 32'h400) begin nMismatched++; $display("FAIL redir_pc: got %h want 400", imemReqAddr); end
    for (int n = 0; n < 40 && !seen; n++) begin
      if (dValid === 1'b1) begin
        seen = 1'b1;
        nCompared++;
        if (uopOut !== {32'h400, encOf(32'h400)}) begin
          nMismatched++;
          $display("FAIL redir_first: got %h want %h", uopOut, {32'h400, encOf(32'h400)});
        end
      end else begin
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      end
    end
    nCompared++;
    if (!seen) begin nMismatched++; $display("FAIL redir_timeout: no uop within 40 cycles, want pc 400"); end
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    drain();
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 0, 1'b0);
    nCompared++;
    if (imemReqAddr !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_align: got %h want fffffffc", imemReqAddr); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    nCompared++;
    if (imemReqAddr !== 32'h0) begin nMismatched++; $display("FAIL wrap_next: got %h want 0", imemReqAddr); end
    for (int n = 0; n < 10 && !seen; n++) begin
      if (dValid === 1'b1) begin
        seen = 1'b1;
        nCompared++;
        if (uopOut[63:32] !== 32'hFFFF_FFFC) begin
          nMismatched++;
          $display("FAIL wrap_uop: got %h want fffffffc", uopOut[63:32]);
        end
      end else begin
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      end
    end
    nCompared++;
    if (!seen) begin nMismatched++; $display("FAIL wrap_timeout: no uop within 10 cycles"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 25) == 0,
            $urandom, int'($urandom % 4), ($urandom % 4) == 0);
      nCompared++;
      if (imemReqValid !== expReqValid()) begin
        nMismatched++;
        $display("FAIL rnd_reqvalid: cyc %0d got %0b want %0b", cyc, imemReqValid, expReqValid());
      end
      nCompared++;
      if (imemReqAddr !== mPc) begin
        nMismatched++;
        $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, imemReqAddr, mPc);
      end
      nCompared++;
      if (dValid !== (bufQ.size() != 0)) begin
        nMismatched++;
        $display("FAIL rnd_dvalid: cyc %0d got %0b want %0b", cyc, dValid, bufQ.size() != 0);
      end
      nCompared++;
      if (uopOut !== expUop()) begin
        nMismatched++;
        $display("FAIL rnd_uop: cyc %0d got %h want %h", cyc, uopOut, expUop());
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit seen = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 0, 1'b0);
    nCompared++;
    if (dValid !== 1'b1) begin nMismatched++; $display("FAIL mid_prefill: dValid=%0b want 1", dValid); end
    #2;
    imemReqReady  = 1'b0;
    imemRespValid = 1'b0;
    dStall        = 1'b0;
    rst           = 1'b1;
    #1;
    nCompared++;
    if (dValid !== 1'b0) begin nMismatched++; $display("FAIL mid_dvalid: got %0b want 0", dValid); end
    nCompared++;
    if (imemReqValid !== 1'b0) begin nMismatched++; $display("FAIL mid_reqvalid: got %0b want 0", imemReqValid); end
    nCompared++;
    if (uopOut !== 64'h0) begin nMismatched++; $display("FAIL mid_uop: got %h want 0", uopOut); end
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    nCompared++;
    if (imemReqValid !== 1'b1 || imemReqAddr !== RPC) begin
      nMismatched++;
      $display("FAIL mid_restart: valid=%0b addr=%h want 1 / %h", imemReqValid, imemReqAddr, RPC);
    end
    for (int n = 0; n < 10 && !seen; n++) begin
      if (dValid === 1'b1) begin
        seen = 1'b1;
        nCompared++;
        if (uopOut !== {RPC, encOf(RPC)}) begin
          nMismatched++;
          $display("FAIL mid_first: got %h want %h", uopOut, {RPC, encOf(RPC)});
        end
      end else begin
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      end
    end
    nCompared++;
    if (!seen) begin nMismatched++; $display("FAIL mid_timeout: no uop within 10 cycles"); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_req_stall();
    test_decode_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
